// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction-decode stage.
// Holds the IF/ID pipeline register and the 32x32 register file with a
// writeback bypass. It decodes register indices and the sign-extended
// immediate that feed the ID/EX register.
module decode_stage #(
   parameter int                XLEN      = 32,
   parameter logic [XLEN-1:0]   NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     InstrF,
   input  logic [XLEN-1:0] PCF,
   input  logic [XLEN-1:0] PC_Plus4F,
   input  logic            StallD,
   input  logic            FlushD,
   input  logic            RegWriteW,
   input  logic [4:0]      RdW,
   input  logic [XLEN-1:0] ResultW,
   output logic [XLEN-1:0] RD1,
   output logic [XLEN-1:0] RD2,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PC_Plus4D,
   output logic [XLEN-1:0] ImmExt_D,
   output logic [4:0]      Rs1D,
   output logic [4:0]      Rs2D,
   output logic [4:0]      RdD,
   output logic            ValidD
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_I_LOAD = 7'b0000011;
   localparam logic [6:0] OP_I_JALR = 7'b1100111;
   localparam logic [6:0] OP_S      = 7'b0100011;
   localparam logic [6:0] OP_B      = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // Immediate extraction; R-type and unknown opcodes carry no immediate.
   function automatic logic signed [XLEN-1:0] imm_gen(input logic [31:0] ins);
      logic signed [XLEN-1:0] imm;
      case (ins[6:0])
         OP_I_ALU, OP_I_LOAD, OP_I_JALR:
            imm = {{20{ins[31]}}, ins[31:20]};
         OP_S:
            imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         OP_B:
            imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         OP_JAL:
            imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         OP_LUI, OP_AUIPC:
            imm = {ins[31:12], 12'b0};
         default:
            imm = '0;
      endcase
      return imm;
   endfunction

   // IF/ID register state
   logic [31:0]     instr_q,    instr_d;
   logic [XLEN-1:0] pc_q,       pc_d;
   logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
   logic            valid_q,    valid_d;

   // Register file state
   logic [XLEN-1:0] rf_q [32];

   // Decoded fields
   logic [6:0]      opcode;
   logic [4:0]      rs1_idx, rs2_idx, rd_idx;
   logic            byp1, byp2;

   // IF/ID next state: flush beats stall, stall holds, otherwise load.
   always_comb begin
      instr_d    = instr_q;
      pc_d       = pc_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
      if (FlushD) begin
         instr_d    = NOP_INSTR;
         pc_d       = '0;
         pc_plus4_d = '0;
         valid_d    = 1'b0;
      end else if (!StallD) begin
         instr_d    = InstrF;
         pc_d       = PCF;
         pc_plus4_d = PC_Plus4F;
         valid_d    = 1'b1;
      end
   end

   // IF/ID pipeline register; reset has priority over flush and stall.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instr_q    <= NOP_INSTR;
         pc_q       <= '0;
         pc_plus4_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         pc_plus4_q <= pc_plus4_d;
         valid_q    <= valid_d;
      end
   end

   // Register file write port; x0 is never written and reset beats a write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            rf_q[i] <= '0;
         end
      end else if (RegWriteW && (RdW != 5'd0)) begin
         rf_q[RdW] <= ResultW;
      end
   end

   // Field decode: zero the indices a format does not use.
   always_comb begin
      opcode  = instr_q[6:0];
      rd_idx  = instr_q[11:7];
      rs1_idx = instr_q[19:15];
      rs2_idx = instr_q[24:20];
      if (opcode == OP_S || opcode == OP_B) begin
         rd_idx = 5'd0;
      end
      if (opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL) begin
         rs1_idx = 5'd0;
         rs2_idx = 5'd0;
      end
      if (opcode == OP_I_ALU || opcode == OP_I_LOAD || opcode == OP_I_JALR) begin
         rs2_idx = 5'd0;
      end
   end

   // Operand read with writeback bypass so a same-cycle write is visible.
   always_comb begin
      byp1 = RegWriteW && (RdW != 5'd0) && (RdW == rs1_idx);
      byp2 = RegWriteW && (RdW != 5'd0) && (RdW == rs2_idx);
      if (byp1) begin
         RD1 = ResultW;
      end else if (rs1_idx == 5'd0) begin
         RD1 = '0;
      end else begin
         RD1 = rf_q[rs1_idx];
      end
      if (byp2) begin
         RD2 = ResultW;
      end else if (rs2_idx == 5'd0) begin
         RD2 = '0;
      end else begin
         RD2 = rf_q[rs2_idx];
      end
   end

   assign Rs1D      = rs1_idx;
   assign Rs2D      = rs2_idx;
   assign RdD       = rd_idx;
   assign ImmExt_D  = imm_gen(instr_q);
   assign PCD       = pc_q;
   assign PC_Plus4D = pc_plus4_q;
   assign ValidD    = valid_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] InstrF, PCF, PC_Plus4F;
   logic        StallD, FlushD;
   logic        RegWriteW;
   logic [4:0]  RdW;
   logic [31:0] ResultW;
   logic [31:0] RD1, RD2, PCD, PC_Plus4D, ImmExt_D;
   logic [4:0]  Rs1D, Rs2D, RdD;
   logic        ValidD;

   int n_checks = 0;
   int n_fail   = 0;

   decode_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .InstrF    (InstrF),
      .PCF       (PCF),
      .PC_Plus4F (PC_Plus4F),
      .StallD    (StallD),
      .FlushD    (FlushD),
      .RegWriteW (RegWriteW),
      .RdW       (RdW),
      .ResultW   (ResultW),
      .RD1       (RD1),
      .RD2       (RD2),
      .PCD       (PCD),
      .PC_Plus4D (PC_Plus4D),
      .ImmExt_D  (ImmExt_D),
      .Rs1D      (Rs1D),
      .Rs2D      (Rs2D),
      .RdD       (RdD),
      .ValidD    (ValidD)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] ins, input logic [31:0] pc);
      InstrF    = ins;
      PCF       = pc;
      PC_Plus4F = pc + 32'd4;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; StallD = 1'b0; FlushD = 1'b0;
      RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'd0;
      fetch(32'h0050_0093, 32'h0000_0100);
      tick(); tick();
      n_checks++; if (Rs1D !== 5'd0 || Rs2D !== 5'd0 || RdD !== 5'd0) begin n_fail++; $display("FAIL reset_idx got rs1=%0d rs2=%0d rd=%0d want 0 0 0", Rs1D, Rs2D, RdD); end
      n_checks++; if (ImmExt_D !== 32'd0) begin n_fail++; $display("FAIL reset_imm got %h want 0", ImmExt_D); end
      n_checks++; if (RD1 !== 32'd0 || RD2 !== 32'd0) begin n_fail++; $display("FAIL reset_rd got %h %h want 0 0", RD1, RD2); end
      n_checks++; if (PCD !== 32'd0 || PC_Plus4D !== 32'd0) begin n_fail++; $display("FAIL reset_pc got %h %h want 0 0", PCD, PC_Plus4D); end
      n_checks++; if (ValidD !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ValidD); end
      rst_n = 1'b1;
      tick();
      n_checks++; if (Rs1D !== 5'd0 || RdD !== 5'd1 || Rs2D !== 5'd0) begin n_fail++; $display("FAIL release_idx got rs1=%0d rs2=%0d rd=%0d want 0 0 1", Rs1D, Rs2D, RdD); end
      n_checks++; if (ImmExt_D !== 32'd5) begin n_fail++; $display("FAIL release_imm got %h want 5", ImmExt_D); end
      n_checks++; if (ValidD !== 1'b1 || PCD !== 32'h100 || PC_Plus4D !== 32'h104) begin n_fail++; $display("FAIL release_pc got v=%b pc=%h pc4=%h want 1 100 104", ValidD, PCD, PC_Plus4D); end
   endtask

   task automatic test_bypass();
      fetch(32'h0031_82B3, 32'h0000_0104);
      tick();
      n_checks++; if (Rs1D !== 5'd3 || Rs2D !== 5'd3 || RdD !== 5'd5) begin n_fail++; $display("FAIL add_idx got rs1=%0d rs2=%0d rd=%0d want 3 3 5", Rs1D, Rs2D, RdD); end
      n_checks++; if (ImmExt_D !== 32'd0) begin n_fail++; $display("FAIL rtype_imm got %h want 0", ImmExt_D); end
      n_checks++; if (RD1 !== 32'd0) begin n_fail++; $display("FAIL pre_write_rd1 got %h want 0", RD1); end
      RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'hDEAD_BEEF;
      #1;
      n_checks++; if (RD1 !== 32'hDEAD_BEEF || RD2 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_same_cycle got %h %h want deadbeef", RD1, RD2); end
      tick();
      RegWriteW = 1'b0; ResultW = 32'h0;
      #1;
      n_checks++; if (RD1 !== 32'hDEAD_BEEF || RD2 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL array_next_cycle got %h %h want deadbeef", RD1, RD2); end
      // add x0,x0,x0 while writing x0
      fetch(32'h0000_0033, 32'h0000_0108);
      tick();
      RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'h1234_5678;
      #1;
      n_checks++; if (RD1 !== 32'd0 || RD2 !== 32'd0) begin n_fail++; $display("FAIL x0_bypass got %h %h want 0 0", RD1, RD2); end
      tick();
      RegWriteW = 1'b0;
      #1;
      n_checks++; if (RD1 !== 32'd0 || RD2 !== 32'd0) begin n_fail++; $display("FAIL x0_array got %h %h want 0 0", RD1, RD2); end
   endtask

   task automatic test_immediates();
      fetch(32'hFE20_AE23, 32'h0000_0200);   // sw x2,-4(x1)
      tick();
      n_checks++; if (ImmExt_D !== 32'hFFFF_FFFC || RdD !== 5'd0) begin n_fail++; $display("FAIL s_imm got imm=%h rd=%0d want fffffffc 0", ImmExt_D, RdD); end
      n_checks++; if (Rs1D !== 5'd1 || Rs2D !== 5'd2) begin n_fail++; $display("FAIL s_idx got rs1=%0d rs2=%0d want 1 2", Rs1D, Rs2D); end
      fetch(32'hFE00_0CE3, 32'h0000_0204);   // beq x0,x0,-8
      tick();
      n_checks++; if (ImmExt_D !== 32'hFFFF_FFF8 || RdD !== 5'd0) begin n_fail++; $display("FAIL b_imm got imm=%h rd=%0d want fffffff8 0", ImmExt_D, RdD); end
      fetch(32'h0010_00EF, 32'h0000_0208);   // jal x1,2048
      tick();
      n_checks++; if (ImmExt_D !== 32'h0000_0800) begin n_fail++; $display("FAIL j_imm got %h want 00000800", ImmExt_D); end
      n_checks++; if (Rs1D !== 5'd0 || Rs2D !== 5'd0 || RdD !== 5'd1) begin n_fail++; $display("FAIL j_idx got rs1=%0d rs2=%0d rd=%0d want 0 0 1", Rs1D, Rs2D, RdD); end
      fetch(32'h1234_53B7, 32'h0000_020C);   // lui x7,0x12345
      tick();
      n_checks++; if (ImmExt_D !== 32'h1234_5000 || RdD !== 5'd7 || Rs1D !== 5'd0) begin n_fail++; $display("FAIL u_imm got imm=%h rd=%0d rs1=%0d want 12345000 7 0", ImmExt_D, RdD, Rs1D); end
      fetch(32'hFFF0_0093, 32'h0000_0210);   // addi x1,x0,-1
      tick();
      n_checks++; if (ImmExt_D !== 32'hFFFF_FFFF || Rs2D !== 5'd0) begin n_fail++; $display("FAIL i_neg_imm got imm=%h rs2=%0d want ffffffff 0", ImmExt_D, Rs2D); end
   endtask

   task automatic test_stall();
      fetch(32'h0050_0093, 32'h0000_0300);   // addi x1,x0,5
      tick();
      StallD = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fetch(32'h1234_53B7 + 32'(i << 7), 32'h0000_0400 + 32'(i * 4));
         tick();
         n_checks++; if (PCD !== 32'h300 || PC_Plus4D !== 32'h304 || ValidD !== 1'b1) begin n_fail++; $display("FAIL stall_hold_pc cyc=%0d got pc=%h pc4=%h v=%b want 300 304 1", i, PCD, PC_Plus4D, ValidD); end
         n_checks++; if (RdD !== 5'd1 || ImmExt_D !== 32'd5) begin n_fail++; $display("FAIL stall_hold_instr cyc=%0d got rd=%0d imm=%h want 1 5", i, RdD, ImmExt_D); end
      end
      StallD = 1'b0;
      fetch(32'h1234_53B7, 32'h0000_0500);
      tick();
      n_checks++; if (PCD !== 32'h500 || ImmExt_D !== 32'h1234_5000 || RdD !== 5'd7) begin n_fail++; $display("FAIL stall_release got pc=%h imm=%h rd=%0d want 500 12345000 7", PCD, ImmExt_D, RdD); end
   endtask

   task automatic test_flush();
      fetch(32'h0031_82B3, 32'h0000_0600);   // reads x3 = deadbeef if loaded
      FlushD = 1'b1; StallD = 1'b1;
      tick();
      FlushD = 1'b0; StallD = 1'b0;
      #1;
      n_checks++; if (PCD !== 32'd0 || PC_Plus4D !== 32'd0 || ValidD !== 1'b0) begin n_fail++; $display("FAIL flush_pc got pc=%h pc4=%h v=%b want 0 0 0", PCD, PC_Plus4D, ValidD); end
      n_checks++; if (RD1 !== 32'd0 || RD2 !== 32'd0 || RdD !== 5'd0 || ImmExt_D !== 32'd0) begin n_fail++; $display("FAIL flush_nop got rd1=%h rd2=%h rd=%0d imm=%h want 0 0 0 0", RD1, RD2, RdD, ImmExt_D); end
   endtask

   task automatic test_reset_mid();
      fetch(32'h0042_0333, 32'h0000_0700);   // add x6,x4,x4
      RegWriteW = 1'b1; RdW = 5'd4; ResultW = 32'h55;
      tick();
      RegWriteW = 1'b0;
      tick();
      n_checks++; if (RD1 !== 32'h55 || RD2 !== 32'h55) begin n_fail++; $display("FAIL x4_written got %h %h want 55 55", RD1, RD2); end
      rst_n = 1'b0; StallD = 1'b1;
      RegWriteW = 1'b1; RdW = 5'd4; ResultW = 32'hAA;
      tick();
      rst_n = 1'b1; StallD = 1'b0; RegWriteW = 1'b0;
      #1;
      n_checks++; if (ValidD !== 1'b0 || PCD !== 32'd0) begin n_fail++; $display("FAIL mid_reset_ifid got v=%b pc=%h want 0 0", ValidD, PCD); end
      tick();
      n_checks++; if (Rs1D !== 5'd4 || RD1 !== 32'd0 || RD2 !== 32'd0) begin n_fail++; $display("FAIL x4_cleared got rs1=%0d rd1=%h rd2=%h want 4 0 0", Rs1D, RD1, RD2); end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_immediates();
      test_stall();
      test_flush();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the pipelined RV32I core: the producer that feeds the ID/EX pipeline register. It captures the fetched instruction into the IF/ID register and extracts register indices. It reads the 32×32 register file with writeback bypass and generates the sign-extended immediate. It presents RD1/RD2/PCD/ImmExt_D/PC_Plus4D/Rs1D/Rs2D/RdD to the execute-side register. The register file write port is driven by the writeback stage; stall and flush come from the hazard unit.

## Interface
Parameters:
- XLEN, 32, datapath width (only 32 supported)
- NOP_INSTR, 32'h0000_0013, instruction loaded on reset/flush (addi x0,x0,0)

Ports:
- clk  input  1  single clock; all state updates on posedge
- rst_n  input  1  synchronous, active-low reset, sampled on posedge clk
- InstrF  input  32  fetched instruction
- PCF  input  32  fetch PC
- PC_Plus4F  input  32  fetch PC+4
- StallD  input  1  hold IF/ID register
- FlushD  input  1  replace IF/ID contents with NOP
- RegWriteW  input  1  writeback write enable
- RdW  input  5  writeback destination
- ResultW  input  32  writeback data
- RD1, RD2  output  32  source operand values
- PCD, PC_Plus4D  output  32  decode-stage PC / PC+4
- ImmExt_D  output  32  sign-extended immediate
- Rs1D, Rs2D, RdD  output  5  register indices
- ValidD  output  1  1 = IF/ID holds a real fetched instruction

## Operation
- **IF/ID register** (InstrD, PCD, PC_Plus4D, ValidD). Priority on posedge: !rst_n > FlushD > StallD > load.
  - Reset/flush: InstrD=NOP_INSTR, PCD=0, PC_Plus4D=0, ValidD=0.
  - Stall: hold all.
  - Load: InstrD=InstrF, PCD=PCF, PC_Plus4D=PC_Plus4F, ValidD=1.
- **Register file**: 32 entries; x0 reads 0 always and is never written.
  - Write on posedge when RegWriteW && RdW!=0 && rst_n.
  - Reset clears all entries to 0; reset wins over a simultaneous write.
  - Writes are independent of StallD/FlushD.
- **Read with bypass** (combinational): RD1 = (RegWriteW && RdW!=0 && RdW==Rs1D) ? ResultW : rf[Rs1D]. RD2 is identical using Rs2D. Rs=0 gives 0.
- **Field decode**, by opcode InstrD[6:0]:
  - RdD = InstrD[11:7]; forced 0 for S (0100011) and B (1100011).
  - Rs1D = InstrD[19:15]; forced 0 for U (0110111, 0010111) and J (1101111).
  - Rs2D = InstrD[24:20]; forced 0 for I-type (0010011, 0000011, 1100111), U and J.
- **Immediate**:
  - I: sext(InstrD[31:20])
  - S: sext({[31:25],[11:7]})
  - B: sext({[31],[7],[30:25],[11:8],1'b0})
  - J: sext({[31],[19:12],[20],[30:21],1'b0})
  - U: {[31:12],12'b0}
  - R-type (0110011) and unknown opcodes: 0.
- Unknown opcodes pass fields raw except Rs2D/Rs1D/RdD as above; no trap generation.

## Timing
- Latency: InstrF sampled at edge N drives decoded outputs after edge N, stable for the ID/EX capture at edge N+1.
- All outputs are combinational from IF/ID and register file state plus the W-stage bypass inputs; no output is registered a second time.
- Reset values (after a posedge with rst_n=0): InstrD=NOP, so Rs1D=0, Rs2D=0 (I-type), RdD=0, ImmExt_D=0, RD1=RD2=0, PCD=PC_Plus4D=0, ValidD=0.
- Simultaneous FlushD and StallD: flush wins.
- Write and read of the same register in one cycle: the new value is visible via the bypass in that cycle and from the array from the next cycle.
- Reset asserted mid-stall: IF/ID and register file cleared on that edge; the stall is ignored.

## Test plan
- Reset: rst_n=0 for 2 cycles with InstrF=0x00500093 -> all outputs 0, ValidD=0; release -> next cycle Rs1D=0, RdD=1, ImmExt_D=5, ValidD=1.
- Writeback/bypass: RegWriteW=1, RdW=3, ResultW=0xDEADBEEF while InstrD=add x5,x3,x3 (0x003182B3) -> RD1=RD2=0xDEADBEEF in the same cycle and held next cycle with RegWriteW=0; write to x0 -> reads of x0 stay 0.
- Immediates:
  - sw x2,-4(x1) (0xFE20AE23) -> ImmExt_D=0xFFFFFFFC, RdD=0.
  - beq x0,x0,-8 (0xFE000CE3) -> 0xFFFFFFF8.
  - jal x1,2048 (0x001000EF) -> 0x00000800, Rs1D=Rs2D=0.
  - lui x7,0x12345 (0x123453B7) -> 0x12345000.
- Stall: StallD=1 for 3 cycles while InstrF/PCF change -> PCD, InstrD-derived outputs and ValidD unchanged; release -> the next fetched instruction loads.
- Flush priority: FlushD=1 and StallD=1 together with valid InstrF -> next cycle InstrD=NOP, PCD=0, ValidD=0, RD1=RD2=0.
- Reset mid-operation: register x4 written with 0x55, then rst_n=0 for one cycle concurrent with RegWriteW=1, RdW=4 -> x4 reads 0 afterwards.
